// File: rtl/toy_vmtx_store_pkg.sv
// rtl/toy_vmtx_store_pkg.sv - shared types for the matrix store engine
package toy_vmtx_store_pkg;

  localparam int V_ELEMENT_NUM        = 4;
  localparam int SHARE_MEM_ADDR_WIDTH = 32;
  localparam int V_REG_WIDTH          = 32;
  localparam int V_REG_IDX_WIDTH      = 5;

  typedef enum logic [4:0] {
    V_OPC_MTX_STORE = 5'b00010
  } opcode_mtx_e;

  typedef struct packed {
    logic [V_REG_IDX_WIDTH-1:0]      vs_idx;
    logic [SHARE_MEM_ADDR_WIDTH-1:0] base_addr;
    logic [SHARE_MEM_ADDR_WIDTH-1:0] stride;
  } vmtx_store_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    REQ,
    WACK,
    DONE
  } vst_state_e;

endpackage

// File: rtl/toy_vmtx_store.sv
// rtl/toy_vmtx_store.sv - MTX_STORE engine: VRF rows to shared-memory writes
// One vreg per row; the row address advances by stride on each accepted write.
module toy_vmtx_store
  import toy_vmtx_store_pkg::*;
#(
  parameter int ELEM_NUM  = V_ELEMENT_NUM,
  parameter int ADDR_W    = SHARE_MEM_ADDR_WIDTH,
  parameter int DATA_W    = V_REG_WIDTH,
  parameter int REG_IDX_W = V_REG_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [REG_IDX_W-1:0] cmd_vs_idx,
  input  logic [ADDR_W-1:0]    cmd_base_addr,
  input  logic [ADDR_W-1:0]    cmd_stride,
  output logic                 vrf_rd_en,
  output logic [REG_IDX_W-1:0] vrf_rd_idx,
  input  logic [DATA_W-1:0]    vrf_rd_data,
  output logic                 mem_req_vld,
  input  logic                 mem_req_rdy,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [DATA_W-1:0]    mem_req_data,
  input  logic                 mem_ack_vld,
  output logic                 busy,
  output logic                 done_vld,
  output logic                 err
);

  localparam int               REQ_W    = $clog2(ELEM_NUM + 1);
  localparam logic [REQ_W-1:0] CNT_FULL = REQ_W'(ELEM_NUM);
  localparam logic [REQ_W-1:0] CNT_LAST = REQ_W'(ELEM_NUM - 1);

  vst_state_e           state_q;
  logic [REQ_W-1:0]     elem_cnt_q;
  logic [REQ_W-1:0]     ack_cnt_q;
  logic [REQ_W-1:0]     ack_cnt_d;
  logic [ADDR_W-1:0]    stride_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [REG_IDX_W-1:0] rd_idx_q;
  logic [DATA_W-1:0]    hold_q;
  logic                 vrf_rd_en_q;
  logic                 mem_req_vld_q;
  logic                 done_vld_q;
  logic                 cmd_rdy_q;
  logic                 busy_q;
  logic                 err_q;
  logic                 ack_take;
  logic                 ack_bad;
  logic                 last_elem;

  // Acks count in any active state until the full count is reached; anything else is stray.
  assign ack_take  = mem_ack_vld && (state_q != IDLE) && (ack_cnt_q != CNT_FULL);
  assign ack_bad   = mem_ack_vld && !ack_take;
  assign ack_cnt_d = ack_cnt_q + REQ_W'(ack_take);
  assign last_elem = (elem_cnt_q >= CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      elem_cnt_q    <= '0;
      ack_cnt_q     <= '0;
      stride_q      <= '0;
      addr_q        <= '0;
      rd_idx_q      <= '0;
      hold_q        <= '0;
      vrf_rd_en_q   <= 1'b0;
      mem_req_vld_q <= 1'b0;
      done_vld_q    <= 1'b0;
      cmd_rdy_q     <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      err_q     <= err_q | ack_bad;
      unique case (state_q)
        IDLE: begin
          if (cmd_vld) begin
            stride_q    <= cmd_stride;
            addr_q      <= cmd_base_addr;
            rd_idx_q    <= cmd_vs_idx;
            elem_cnt_q  <= '0;
            ack_cnt_q   <= '0;
            vrf_rd_en_q <= 1'b1;
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RD;
          end
        end
        RD: begin
          vrf_rd_en_q <= 1'b0;
          state_q     <= CAP;
        end
        CAP: begin
          hold_q        <= vrf_rd_data;
          mem_req_vld_q <= 1'b1;
          state_q       <= REQ;
        end
        REQ: begin
          if (mem_req_rdy) begin
            mem_req_vld_q <= 1'b0;
            elem_cnt_q    <= elem_cnt_q + 1'b1;
            if (!last_elem) begin
              addr_q      <= addr_q + stride_q;
              rd_idx_q    <= rd_idx_q + 1'b1;
              vrf_rd_en_q <= 1'b1;
              state_q     <= RD;
            end else if (ack_cnt_d == CNT_FULL) begin
              done_vld_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              state_q <= WACK;
            end
          end
        end
        WACK: begin
          if (ack_cnt_d == CNT_FULL) begin
            done_vld_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_vld_q <= 1'b0;
          cmd_rdy_q  <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_rdy      = cmd_rdy_q;
  assign busy         = busy_q;
  assign vrf_rd_en    = vrf_rd_en_q;
  assign vrf_rd_idx   = rd_idx_q;
  assign mem_req_vld  = mem_req_vld_q;
  assign mem_req_addr = addr_q;
  assign mem_req_data = hold_q;
  assign done_vld     = done_vld_q;
  assign err          = err_q;

endmodule

// File: tb/tb_toy_vmtx_store.sv
// tb/tb_toy_vmtx_store.sv - self-checking bench for the matrix store engine
// VRF and memory are modelled at negedge; expected writes come from base + k*stride.
module tb_toy_vmtx_store;

  localparam int ELEM = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [4:0]  cmd_vs_idx;
  logic [31:0] cmd_base_addr;
  logic [31:0] cmd_stride;
  logic        vrf_rd_en;
  logic [4:0]  vrf_rd_idx;
  logic [31:0] vrf_rd_data = 32'h0;
  logic        mem_req_vld;
  logic        mem_req_rdy = 1'b1;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_ack_vld = 1'b0;
  logic        busy;
  logic        done_vld;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] vrf_mem [32];
  logic [4:0]  cur_vs = 5'd0;
  logic [31:0] cur_base = 32'h0;
  logic [31:0] cur_stride = 32'h0;
  int          stall_row = -1;
  int          stall_len = 0;
  int          late_ack_req = 0;
  bit          ack_hold = 1'b0;
  bit          rand_rdy = 1'b0;

  int          cyc = 0;
  int          row = 0;
  int          stall_left = 0;
  int          withheld = 0;
  int          late_sent = 0;
  int          done_cyc = 0;
  int          last_ack_cyc = 0;
  bit          ack_pipe = 1'b0;
  bit          prev_busy = 1'b0;
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  logic [4:0]  got_ridx [$];

  toy_vmtx_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_vld      (cmd_vld),
    .cmd_rdy      (cmd_rdy),
    .cmd_vs_idx   (cmd_vs_idx),
    .cmd_base_addr(cmd_base_addr),
    .cmd_stride   (cmd_stride),
    .vrf_rd_en    (vrf_rd_en),
    .vrf_rd_idx   (vrf_rd_idx),
    .vrf_rd_data  (vrf_rd_data),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_addr (mem_req_addr),
    .mem_req_data (mem_req_data),
    .mem_ack_vld  (mem_ack_vld),
    .busy         (busy),
    .done_vld     (done_vld),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Environment: VRF read port, memory request acceptance and ack return.
  always @(negedge clk) begin
    cyc++;
    mem_ack_vld = 1'b0;
    if (!rst_n) begin
      ack_pipe = 1'b0;
      withheld = 0;
    end else if (ack_pipe) begin
      mem_ack_vld = 1'b1;
      ack_pipe    = 1'b0;
    end else if (!ack_hold && withheld > 0) begin
      mem_ack_vld = 1'b1;
      withheld--;
      if (withheld == 0) last_ack_cyc = cyc;
    end else if (late_sent < late_ack_req) begin
      mem_ack_vld = 1'b1;
      late_sent++;
    end
    if (busy && !prev_busy) begin
      row        = 0;
      stall_left = stall_len;
      got_addr.delete();
      got_data.delete();
      got_ridx.delete();
    end
    prev_busy = busy;
    if (vrf_rd_en) begin
      vrf_rd_data = vrf_mem[vrf_rd_idx];
      got_ridx.push_back(vrf_rd_idx);
    end
    if (done_vld) done_cyc = cyc;
    mem_req_rdy = 1'b1;
    if (rst_n && mem_req_vld) begin
      if (row == stall_row && stall_left > 0) begin
        mem_req_rdy = 1'b0;
        stall_left--;
      end else if (rand_rdy && $urandom_range(0, 3) == 0) begin
        mem_req_rdy = 1'b0;
      end
      check("req_addr", mem_req_addr, cur_base + 32'(row) * cur_stride);
      check("req_data", mem_req_data, vrf_mem[cur_vs + 5'(row)]);
      if (mem_req_rdy) begin
        got_addr.push_back(mem_req_addr);
        got_data.push_back(mem_req_data);
        row++;
        if (ack_hold) withheld++;
        else ack_pipe = 1'b1;
      end
    end
  end

  task automatic start_cmd(input logic [4:0] vs, input logic [31:0] base, input logic [31:0] stride);
    cur_vs        = vs;
    cur_base      = base;
    cur_stride    = stride;
    cmd_vs_idx    = vs;
    cmd_base_addr = base;
    cmd_stride    = stride;
    cmd_vld       = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_vld && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(done_vld), 1);
  endtask

  task automatic check_writes(input logic [4:0] vs, input logic [31:0] base, input logic [31:0] stride);
    logic [31:0] ea;
    logic [4:0]  ri;
    check("n_writes", got_addr.size(), ELEM);
    check("n_reads", got_ridx.size(), ELEM);
    for (int k = 0; k < ELEM; k++) begin
      ea = base + 32'(k) * stride;
      ri = 5'((int'(vs) + k) % 32);
      if (k < got_addr.size()) begin
        check("wr_addr", got_addr[k], ea);
        check("wr_data", got_data[k], vrf_mem[ri]);
      end
      if (k < got_ridx.size()) check("rd_idx", 32'(got_ridx[k]), 32'(ri));
    end
  endtask

  task automatic run_cmd(input logic [4:0] vs, input logic [31:0] base, input logic [31:0] stride,
                         input int exp_lat);
    int lat;
    start_cmd(vs, base, stride);
    wait_done(lat);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check_writes(vs, base, stride);
    @(negedge clk);
    check("rdy_after_done", 32'(cmd_rdy), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, 32'(cmd_rdy), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_done"}, 32'(done_vld), 0);
    check({tag, "_req_vld"}, 32'(mem_req_vld), 0);
    check({tag, "_rd_en"}, 32'(vrf_rd_en), 0);
    check({tag, "_rd_idx"}, 32'(vrf_rd_idx), 0);
    check({tag, "_addr"}, mem_req_addr, 0);
    check({tag, "_data"}, mem_req_data, 0);
  endtask

  initial begin
    int lat;
    int n;
    logic [4:0]  rvs;
    logic [31:0] rbase;
    logic [31:0] rstride;
    cmd_vld       = 1'b0;
    cmd_vs_idx    = 5'd0;
    cmd_base_addr = 32'h0;
    cmd_stride    = 32'h0;
    rst_n         = 1'b0;
    for (int i = 0; i < 32; i++) vrf_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(5'd4, 32'h100, 32'h4, 14);
    check("basic_err", 32'(err), 0);

    stall_row = 2;
    stall_len = 5;
    run_cmd(5'd12, 32'h3000, 32'h20, 19);
    stall_row = -1;
    stall_len = 0;

    run_cmd(5'd30, 32'hFFFF_FFF8, 32'h4, 14);
    run_cmd(5'($urandom), $urandom, 32'h0, 14);

    rand_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rvs     = 5'($urandom);
      rbase   = $urandom;
      rstride = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_cmd(rvs, rbase, rstride, -1);
    end
    rand_rdy = 1'b0;
    check("random_err", 32'(err), 0);

    ack_hold = 1'b1;
    start_cmd(5'd9, 32'h2000, 32'h10);
    n = 0;
    while (withheld < ELEM && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("withheld_acks", withheld, ELEM);
    repeat (3) @(negedge clk);
    check("wack_busy", 32'(busy), 1);
    check("wack_no_done", 32'(done_vld), 0);
    ack_hold = 1'b0;
    wait_done(lat);
    check_writes(5'd9, 32'h2000, 32'h10);
    @(negedge clk);
    check("done_after_last_ack", done_cyc - last_ack_cyc, 1);
    check("late_err_clear", 32'(err), 0);
    late_ack_req++;
    repeat (2) @(negedge clk);
    check("err_extra_ack", 32'(err), 1);

    stall_row = 1;
    stall_len = 20;
    start_cmd(5'd3, 32'h400, 32'h8);
    n = 0;
    while (!(mem_req_vld && mem_req_addr == 32'h408) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_row1", 32'(mem_req_vld), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midop");
    stall_row = -1;
    stall_len = 0;
    @(negedge clk);
    rst_n = 1'b1;
    late_ack_req++;
    repeat (2) @(negedge clk);
    check("err_late_ack", 32'(err), 1);
    run_cmd(5'd6, 32'h800, 32'h4, 14);
    check("err_sticky", 32'(err), 1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("b2b_err_cleared", 32'(err), 0);
    cur_vs        = 5'd20;
    cur_base      = 32'h5000;
    cur_stride    = 32'h40;
    cmd_vs_idx    = 5'd20;
    cmd_base_addr = 32'h5000;
    cmd_stride    = 32'h40;
    cmd_vld       = 1'b1;
    @(negedge clk);
    wait_done(lat);
    check("b2b_lat_a", lat, 14);
    check("b2b_rdy_in_done", 32'(cmd_rdy), 0);
    check_writes(5'd20, 32'h5000, 32'h40);
    cur_vs        = 5'd28;
    cur_base      = 32'h6000;
    cur_stride    = 32'hC;
    cmd_vs_idx    = 5'd28;
    cmd_base_addr = 32'h6000;
    cmd_stride    = 32'hC;
    @(negedge clk);
    check("b2b_rdy_idle", 32'(cmd_rdy), 1);
    @(negedge clk);
    cmd_vld = 1'b0;
    check("b2b_busy", 32'(busy), 1);
    wait_done(lat);
    check("b2b_lat_b", lat, 14);
    check_writes(5'd28, 32'h6000, 32'hC);
    check("b2b_err", 32'(err), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
